// File: rtl/param_fifo_queue_pkg.sv
// -----------------------------------------------------------------------------
// param_fifo_queue_pkg
//   Shared constants and helpers for the parametrised request FIFO and its
//   pointer/occupancy controller.
//   Contents:
//     DEFAULT_ENTRY_WIDTH  default payload width in bits
//     DEFAULT_QUEUE_SIZE   default entry count
//     wrap_inc()           ring-pointer increment that wraps at an arbitrary
//                          size; the depth need not be a power of two
// -----------------------------------------------------------------------------
package param_fifo_queue_pkg;

  localparam int unsigned DEFAULT_ENTRY_WIDTH = 64;
  localparam int unsigned DEFAULT_QUEUE_SIZE  = 8;

  // Wrap by comparison rather than by bit truncation so that odd depths such
  // as 5 or 7 cycle through exactly QUEUE_SIZE slots.
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned size);
    return (ptr == size - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_fifo_queue_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Ring-buffer bookkeeping for a single-clock FIFO of any depth >= 2:
//   wrapped read/write pointers, occupancy count and status flags. It holds
//   no payload, so later multi-channel queues can reuse it per channel.
//   Ports:
//     clk           in   clock, rising edge
//     reset_n       in   synchronous reset, active low
//     flush         in   synchronous clear of pointers and count
//     push          in   an entry is written this cycle
//     pop           in   the head entry is consumed this cycle
//     write_ptr     out  slot the next pushed entry goes to
//     head_next_ptr out  slot after the current head (wrapped)
//     count         out  registered occupancy
//     count_next    out  occupancy after this edge
//     is_empty      out  count == 0
//     is_full       out  count == QUEUE_SIZE
//     almost_empty  out  count <= ALMOST_EMPTY_THRESHOLD
//     almost_full   out  count >= ALMOST_FULL_THRESHOLD
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl
  import param_fifo_queue_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE             = DEFAULT_QUEUE_SIZE,
  parameter int unsigned PTR_W                  = $clog2(QUEUE_SIZE),
  parameter int unsigned COUNT_W                = $clog2(QUEUE_SIZE + 1),
  parameter int unsigned ALMOST_FULL_THRESHOLD  = QUEUE_SIZE - 1,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  output logic [PTR_W-1:0]   write_ptr,
  output logic [PTR_W-1:0]   head_next_ptr,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] count_next,
  output logic               is_empty,
  output logic               is_full,
  output logic               almost_empty,
  output logic               almost_full
);

  logic [PTR_W-1:0] read_ptr;
  logic [PTR_W-1:0] write_ptr_inc;

  assign head_next_ptr = PTR_W'(wrap_inc(32'(read_ptr), QUEUE_SIZE));
  assign write_ptr_inc = PTR_W'(wrap_inc(32'(write_ptr), QUEUE_SIZE));

  // The caller only pushes when not full (or when the head drains in the
  // same cycle) and only pops when non-empty, so count stays in range.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + COUNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - COUNT_W'(1);
    end
  end

  // Flags decode the registered count so they never depend on this cycle's
  // handshakes.
  assign is_empty     = (count == '0);
  assign is_full      = (32'(count) == QUEUE_SIZE);
  assign almost_empty = (32'(count) <= ALMOST_EMPTY_THRESHOLD);
  assign almost_full  = (32'(count) >= ALMOST_FULL_THRESHOLD);

  // ---- pointer / count register stage ----
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      read_ptr  <= '0;
      write_ptr <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        write_ptr <= write_ptr_inc;
      end
      if (pop) begin
        read_ptr <= head_next_ptr;
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/param_fifo_queue.sv
// -----------------------------------------------------------------------------
// param_fifo_queue
//   Single-clock request FIFO of QUEUE_SIZE entries (any depth >= 2) with a
//   registered head, bubble-free back-to-back reads, occupancy count,
//   almost-full/almost-empty flags, synchronous flush and an optional
//   full-pass mode that accepts a write while the head drains.
//   Ports:
//     clk_in            in   clock, rising edge
//     reset_n_in        in   synchronous reset, active low
//     flush_in          in   synchronous clear of all contents
//     request_in        in   write payload
//     request_valid_in  in   write request
//     issue_ack_out     out  write accepted if request_valid_in is high
//     request_out       out  head payload (registered)
//     request_valid_out out  head valid (registered)
//     issue_ack_in      in   consumer takes the head when it is valid
//     is_empty_out      out  count == 0
//     is_full_out       out  count == QUEUE_SIZE
//     almost_empty_out  out  count <= ALMOST_EMPTY_THRESHOLD
//     almost_full_out   out  count >= ALMOST_FULL_THRESHOLD
//     count_out         out  accepted, not yet consumed entries incl. head
// -----------------------------------------------------------------------------
module param_fifo_queue
  import param_fifo_queue_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH,
  parameter int unsigned QUEUE_SIZE                 = DEFAULT_QUEUE_SIZE,
  parameter int unsigned QUEUE_PTR_WIDTH_IN_BITS    = $clog2(QUEUE_SIZE),
  parameter int unsigned COUNT_WIDTH_IN_BITS        = $clog2(QUEUE_SIZE + 1),
  parameter int unsigned ALMOST_FULL_THRESHOLD      = QUEUE_SIZE - 1,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD     = 1,
  parameter bit          FULL_PASS_EN               = 1'b0
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic                                  flush_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic                                  request_valid_out,
  input  logic                                  issue_ack_in,
  output logic                                  is_empty_out,
  output logic                                  is_full_out,
  output logic                                  almost_empty_out,
  output logic                                  almost_full_out,
  output logic [COUNT_WIDTH_IN_BITS-1:0]        count_out
);

  localparam int unsigned W = SINGLE_ENTRY_WIDTH_IN_BITS;

  logic [W-1:0]                       mem [QUEUE_SIZE];
  logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] write_ptr;
  logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] head_next_ptr;
  logic [COUNT_WIDTH_IN_BITS-1:0]     count_next;
  logic                               push;
  logic                               pop;
  logic                               head_from_mem;
  logic [W-1:0]                       head_next;

  assign pop = request_valid_out & issue_ack_in;

  // Only the full-pass build gets a combinational issue_ack_in -> issue_ack_out
  // path; the default build decodes acceptance from registered state alone.
  if (FULL_PASS_EN) begin : g_full_pass
    assign issue_ack_out = ~flush_in & (~is_full_out | pop);
  end else begin : g_no_pass
    assign issue_ack_out = ~flush_in & ~is_full_out;
  end

  assign push = request_valid_in & issue_ack_out;

  fifo_ptr_ctrl #(
    .QUEUE_SIZE             (QUEUE_SIZE),
    .PTR_W                  (QUEUE_PTR_WIDTH_IN_BITS),
    .COUNT_W                (COUNT_WIDTH_IN_BITS),
    .ALMOST_FULL_THRESHOLD  (ALMOST_FULL_THRESHOLD),
    .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD)
  ) u_ptr_ctrl (
    .clk           (clk_in),
    .reset_n       (reset_n_in),
    .flush         (flush_in),
    .push          (push),
    .pop           (pop),
    .write_ptr     (write_ptr),
    .head_next_ptr (head_next_ptr),
    .count         (count_out),
    .count_next    (count_next),
    .is_empty      (is_empty_out),
    .is_full       (is_full_out),
    .almost_empty  (almost_empty_out),
    .almost_full   (almost_full_out)
  );

  // ---- storage write stage ----
  // Every accepted entry lands in the regfile, including the one that is
  // also copied straight into the head register. Storage is not reset: the
  // pointers alone decide which slots hold live data.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[write_ptr] <= request_in;
    end
  end

  // The entry behind the head already sits in the regfile whenever at least
  // two entries are held, so a pop can refill the head from there in the same
  // cycle. With one or zero entries the only candidate is the incoming write.
  // In full-pass mode the write lands in the slot the head vacates, which is
  // never the slot read here because QUEUE_SIZE >= 2.
  assign head_from_mem = pop && (32'(count_out) > 1);

  always_comb begin
    head_next = request_out;
    if (head_from_mem) begin
      head_next = mem[head_next_ptr];
    end else if (push && (pop || is_empty_out)) begin
      head_next = request_in;
    end
  end

  // ---- head register stage ----
  always_ff @(posedge clk_in) begin
    if (!reset_n_in || flush_in) begin
      request_out       <= '0;
      request_valid_out <= 1'b0;
    end else begin
      request_out       <= head_next;
      request_valid_out <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_param_fifo_queue.sv
// Bench for param_fifo_queue: two depth-5 instances, one without and one with
// full-pass, driven by the same stimulus and each compared every cycle with a
// queue-based reference model.
module tb_param_fifo_queue;

  localparam int QS = 5;
  localparam int W  = 16;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [W-1:0] din;
  logic         vin;
  logic         ack_in;

  logic          ack_np, vld_np, empty_np, full_np, ae_np, af_np;
  logic [W-1:0]  rout_np;
  logic [CW-1:0] cnt_np;
  logic          ack_fp, vld_fp, empty_fp, full_fp, ae_fp, af_fp;
  logic [W-1:0]  rout_fp;
  logic [CW-1:0] cnt_fp;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q_np[$];
  logic [W-1:0] q_fp[$];
  bit           clr_np, clr_fp;

  always #5 clk = ~clk;

  param_fifo_queue #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(W), .QUEUE_SIZE(QS),
    .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(1), .FULL_PASS_EN(1'b0)
  ) dut_np (
    .clk_in(clk), .reset_n_in(rst_n), .flush_in(flush),
    .request_in(din), .request_valid_in(vin), .issue_ack_out(ack_np),
    .request_out(rout_np), .request_valid_out(vld_np), .issue_ack_in(ack_in),
    .is_empty_out(empty_np), .is_full_out(full_np),
    .almost_empty_out(ae_np), .almost_full_out(af_np), .count_out(cnt_np)
  );

  param_fifo_queue #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(W), .QUEUE_SIZE(QS),
    .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(1), .FULL_PASS_EN(1'b1)
  ) dut_fp (
    .clk_in(clk), .reset_n_in(rst_n), .flush_in(flush),
    .request_in(din), .request_valid_in(vin), .issue_ack_out(ack_fp),
    .request_out(rout_fp), .request_valid_out(vld_fp), .issue_ack_in(ack_in),
    .is_empty_out(empty_fp), .is_full_out(full_fp),
    .almost_empty_out(ae_fp), .almost_full_out(af_fp), .count_out(cnt_fp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the occupancy and the front of the model
  // queue alone.
  task automatic chk_dut(input string n, input int size, input logic [W-1:0] head,
                         input bit cleared, input bit exp_ack,
                         input logic o_ack, input logic o_vld, input logic [W-1:0] o_rout,
                         input logic o_empty, input logic o_full, input logic o_ae,
                         input logic o_af, input logic [CW-1:0] o_cnt);
    chk({n, ".count"}, 64'(o_cnt), 64'(size));
    chk({n, ".valid"}, 64'(o_vld), 64'(size > 0));
    chk({n, ".empty"}, 64'(o_empty), 64'(size == 0));
    chk({n, ".full"}, 64'(o_full), 64'(size == QS));
    chk({n, ".almost_empty"}, 64'(o_ae), 64'(size <= 1));
    chk({n, ".almost_full"}, 64'(o_af), 64'(size >= 4));
    chk({n, ".ack"}, 64'(o_ack), 64'(exp_ack));
    if (size > 0) chk({n, ".head"}, 64'(o_rout), 64'(head));
    else if (cleared) chk({n, ".head_zero"}, 64'(o_rout), 64'd0);
  endtask

  // One clock cycle: apply inputs after the falling edge, check outputs, then
  // advance both models across the rising edge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [W-1:0] d, input logic a);
    bit pop_np, pop_fp, eack_np, eack_fp, push_np, push_fp;
    logic [W-1:0] h_np, h_fp;
    rst_n = r; flush = f; vin = v; din = d; ack_in = a;
    #1;
    pop_np  = (q_np.size() > 0) && a;
    pop_fp  = (q_fp.size() > 0) && a;
    eack_np = !f && (q_np.size() < QS);
    eack_fp = !f && ((q_fp.size() < QS) || pop_fp);
    push_np = v && eack_np;
    push_fp = v && eack_fp;
    h_np = (q_np.size() > 0) ? q_np[0] : '0;
    h_fp = (q_fp.size() > 0) ? q_fp[0] : '0;
    chk_dut("np", q_np.size(), h_np, clr_np, eack_np, ack_np, vld_np, rout_np,
            empty_np, full_np, ae_np, af_np, cnt_np);
    chk_dut("fp", q_fp.size(), h_fp, clr_fp, eack_fp, ack_fp, vld_fp, rout_fp,
            empty_fp, full_fp, ae_fp, af_fp, cnt_fp);
    @(posedge clk);
    if (!r || f) begin
      q_np.delete(); q_fp.delete(); clr_np = 1; clr_fp = 1;
    end else begin
      if (pop_np) void'(q_np.pop_front());
      if (pop_fp) void'(q_fp.pop_front());
      if (push_np) begin q_np.push_back(d); clr_np = 0; end
      if (push_fp) begin q_fp.push_back(d); clr_fp = 0; end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] vals [5];
    vals = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55};
    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; din = '0; ack_in = 1'b0;
    clr_np = 1; clr_fp = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then fill to full with the consumer stalled.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, vals[i], 1'b0);
    chk("t1.count_full", 64'(cnt_np), 64'd5);
    chk("t1.is_full", 64'(full_np), 64'd1);
    chk("t1.ack_low", 64'(ack_np), 64'd0);
    // Sixth write dropped; head stays 0x11 while stalled.
    step(1'b1, 1'b0, 1'b1, 16'h66, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("t1.head_stable", 64'(rout_np), 64'h11);

    // Drain five in a row, no bubbles, wrapping the read pointer.
    for (int i = 0; i < 5; i++) begin
      chk("t2.drain_head", 64'(rout_np), 64'(vals[i]));
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    end
    chk("t2.empty", 64'(empty_np), 64'd1);
    chk("t2.valid_low", 64'(vld_np), 64'd0);

    // Single write into an empty queue shows up on the next cycle.
    step(1'b1, 1'b0, 1'b1, 16'hA5, 1'b0);
    chk("t3.head", 64'(rout_np), 64'hA5);
    chk("t3.count", 64'(cnt_np), 64'd1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Refill, then write while the head drains on a full queue.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, vals[i], 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h77, 1'b1);
    chk("t4.fp_count", 64'(cnt_fp), 64'd5);
    chk("t4.np_count", 64'(cnt_np), 64'd4);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush with a concurrent write: the write never appears.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, vals[i], 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h99, 1'b1);
    chk("t5.count", 64'(cnt_np), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Reset mid-operation with a pop pending.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, vals[i], 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hBB, 1'b1);
    chk("t6.count", 64'(cnt_fp), 64'd0);
    chk("t6.head", 64'(rout_fp), 64'd0);

    // Random sweep of pushes, pops, rare flushes and resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6),
           W'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
